data_ram_ctrl: RTL

//  Parametrised byte-addressable data RAM with a req/ready command handshake.

---
 rtl/data_ram_if.sv | 18 +
 rtl/data_ram_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/data_ram_if.sv
// Command/response bus between a load/store client and data_ram_ctrl.
// The master drives the command and the slave returns ready and the response.
interface data_ram_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  req;
   logic                  ready;
   logic                  we;
   logic [2:0]            strb;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           wData;
   logic                  done;
   logic                  err;
   logic [31:0]           rData;

   modport master (output req, we, strb, addr, wData, input ready, done, err, rData);
   modport slave  (input req, we, strb, addr, wData, output ready, done, err, rData);
endinterface

// File: rtl/data_ram_ctrl.sv
// Byte-addressable data RAM with a req/ready handshake, programmable wait states,
// RV32 load/store sizing and an error response for bad accesses.
module data_ram_ctrl #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DEPTH_BYTES = 1024,
   parameter int WAIT_STATES = 2
) (
   input logic       clk,
   input logic       reset_n,
   data_ram_if.slave bus
);
   localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]            state;
   logic [3:0]            wait_cnt;
   logic                  we_q;
   logic [2:0]            strb_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  done_q;
   logic                  err_q;
   logic [31:0]           rdata_q;

   logic [7:0]            mem [DEPTH_BYTES];

   logic [2:0]            size;
   logic [ADDR_WIDTH:0]   end_addr;
   logic                  bad;
   logic                  last;
   logic [31:0]           raw;
   logic [31:0]           load_val;

   assign bus.ready = reset_n && (state == IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rData = rdata_q;

   assign last = (state == ACCESS) && (wait_cnt == 4'(WAIT_STATES));

   // All checks use the latched command; the end address gets one extra bit so
   // accesses near the top of the address space cannot wrap back into range.
   always_comb begin
      case (strb_q[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
      end_addr = {1'b0, addr_q} + (ADDR_WIDTH+1)'(size);
      bad = (strb_q[1:0] == 2'b11)
         || (strb_q == 3'b110)
         || (we_q && strb_q[2])
         || ((strb_q[1:0] == 2'b01) && addr_q[0])
         || ((strb_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00))
         || (end_addr > (ADDR_WIDTH+1)'(DEPTH_BYTES));
   end

   // Unused upper bytes stay zero, so BU/HU need no explicit zero-extension.
   always_comb begin
      raw = '0;
      for (int i = 0; i < 4; i++)
         if (3'(i) < size)
            raw[8*i +: 8] = mem[IDX_W'(addr_q + ADDR_WIDTH'(i))];
      case (strb_q)
         3'b000:  load_val = {{24{raw[7]}}, raw[7:0]};
         3'b001:  load_val = {{16{raw[15]}}, raw[15:0]};
         default: load_val = raw;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
         we_q     <= 1'b0;
         strb_q   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req) begin
                  we_q     <= bus.we;
                  strb_q   <= bus.strb;
                  addr_q   <= bus.addr;
                  wdata_q  <= bus.wData;
                  wait_cnt <= '0;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               if (last) begin
                  state  <= RESP;
                  done_q <= 1'b1;
                  err_q  <= bad;
                  if (bad)       rdata_q <= '0;
                  else if (!we_q) rdata_q <= load_val;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Storage is never reset; a reset during ACCESS suppresses the pending write.
   always_ff @(posedge clk) begin
      if (reset_n && last && we_q && !bad)
         for (int i = 0; i < 4; i++)
            if (3'(i) < size)
               mem[IDX_W'(addr_q + ADDR_WIDTH'(i))] <= wdata_q[8*i +: 8];
   end
endmodule
